// File: rtl/adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } sa_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa.sv
// One-bit full adder cell driven by the serial adder controller.
module fa (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds operand bits LSB-first through one fa cell
// and recirculates the carry, producing {cout,sum} = op_a + op_b + cin.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_next;
    logic [CW-1:0]    count;
    logic             carry;
    logic             fa_s;
    logic             fa_cout;

    fa u_fa (
        .A   (a_sr[0]),
        .B   (b_sr[0]),
        .Cin (carry),
        .S   (fa_s),
        .Cout(fa_cout)
    );

    // New sum bit enters at the MSB; the cast form also covers WIDTH=1.
    assign s_next = WIDTH'({fa_s, s_sr} >> 1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            count <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= op_a;
                        b_sr  <= op_b;
                        carry <= cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_next;
                    carry <= fa_cout;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        // carry here is the carry into the MSB
                        sum   <= s_next;
                        cout  <= fa_cout;
                        ovf   <= fa_cout ^ carry;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance plus a 1-bit instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] op_a8, op_b8;
    logic [0:0] op_a1, op_b1;
    logic       cin8, cin1;
    logic       busy8, done8, cout8, ovf8;
    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum8;
    logic [0:0] sum1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_a(op_a8), .op_b(op_b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1),
        .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    // Returns cycles from the call until done is seen (sampled #1 after each edge), -1 on timeout.
    task automatic wait_done(input bit w1, output int cycles);
        cycles = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            cycles++;
            if (w1 ? done1 : done8) return;
        end
        cycles = -1;
    endtask

    // Pulses start for one edge (E0) on the 8-bit instance; returns #1 after E0.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        op_a8  = a;
        op_b8  = b;
        cin8   = c;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 1'b0; start1 = 1'b0;
        op_a8 = '0; op_b8 = '0; cin8 = 1'b0;
        op_a1 = '0; op_b1 = '0; cin1 = 1'b0;
        #12;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            $display("FAIL reset8 got %h expected 000", {busy8, done8, sum8, cout8, ovf8});
            failures++;
        end
        checks++;
        if ({busy1, done1, sum1, cout1, ovf1} !== 5'b0) begin
            $display("FAIL reset1 got %b expected 00000", {busy1, done1, sum1, cout1, ovf1});
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vector(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic c, input logic [7:0] exp_sum, input logic exp_cout,
                              input logic exp_ovf);
        int cyc;
        launch8(a, b, c);
        checks++;
        if (busy8 !== 1'b1) begin
            $display("FAIL %s busy_after_start got %b expected 1", name, busy8);
            failures++;
        end
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== 8) begin
            $display("FAIL %s latency got %0d expected 8", name, cyc);
            failures++;
        end
        checks++;
        if ({busy8, sum8, cout8, ovf8} !== {1'b0, exp_sum, exp_cout, exp_ovf}) begin
            $display("FAIL %s result got busy=%b sum=%h cout=%b ovf=%b expected busy=0 sum=%h cout=%b ovf=%b",
                     name, busy8, sum8, cout8, ovf8, exp_sum, exp_cout, exp_ovf);
            failures++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (done8 !== 1'b0) begin
            $display("FAIL %s done_pulse_width got %b expected 0", name, done8);
            failures++;
        end
    endtask

    task automatic test_basic;
        run_vector("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_vector("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_vector("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_vector("add_00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_start;
        int cyc;
        launch8(8'h5A, 8'h3C, 1'b0);
        op_a8  = 8'h11;
        op_b8  = 8'h22;
        cin8   = 1'b1;
        start8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start8 = 1'b0;
        checks++;
        if ({busy8, sum8, cout8, ovf8} !== {1'b1, 8'h01, 1'b0, 1'b0}) begin
            $display("FAIL ignored_start_hold got busy=%b sum=%h cout=%b ovf=%b expected busy=1 sum=01 cout=0 ovf=0",
                     busy8, sum8, cout8, ovf8);
            failures++;
        end
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== 6) begin
            $display("FAIL ignored_start_latency got %0d expected 6", cyc);
            failures++;
        end
        checks++;
        if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
            $display("FAIL ignored_start_result got sum=%h cout=%b ovf=%b expected sum=96 cout=0 ovf=1",
                     sum8, cout8, ovf8);
            failures++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b0) begin
            $display("FAIL ignored_start_no_restart got busy=%b expected 0", busy8);
            failures++;
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        @(negedge clk);
        op_a8  = 8'h10;
        op_b8  = 8'h20;
        cin8   = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        op_a8 = 8'h40;
        op_b8 = 8'h05;
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== 8 || sum8 !== 8'h30) begin
            $display("FAIL b2b_first got cycles=%0d sum=%h expected cycles=8 sum=30", cyc, sum8);
            failures++;
        end
        wait_done(1'b0, cyc);
        start8 = 1'b0;
        checks++;
        if (cyc !== 9 || {sum8, cout8, ovf8} !== {8'h45, 1'b0, 1'b0}) begin
            $display("FAIL b2b_second got cycles=%0d sum=%h cout=%b ovf=%b expected cycles=9 sum=45 cout=0 ovf=0",
                     cyc, sum8, cout8, ovf8);
            failures++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b0) begin
            $display("FAIL b2b_stop got busy=%b expected 0", busy8);
            failures++;
        end
    endtask

    task automatic test_reset_mid_run;
        bit seen_done = 1'b0;
        launch8(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            $display("FAIL reset_mid_run got %h expected 000", {busy8, done8, sum8, cout8, ovf8});
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done8) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || busy8 !== 1'b0) begin
            $display("FAIL reset_no_done got done_seen=%b busy=%b expected 0 0", seen_done, busy8);
            failures++;
        end
        run_vector("after_reset_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    endtask

    task automatic test_width1;
        int cyc;
        @(negedge clk);
        op_a1  = 1'b1;
        op_b1  = 1'b1;
        cin1   = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(1'b1, cyc);
        checks++;
        if (cyc !== 1) begin
            $display("FAIL w1_latency got %0d expected 1", cyc);
            failures++;
        end
        checks++;
        if ({sum1, cout1, ovf1} !== 3'b110) begin
            $display("FAIL w1_result got sum=%b cout=%b ovf=%b expected sum=1 cout=1 ovf=0",
                     sum1, cout1, ovf1);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
